// File: rtl/or_bus_arbiter_pkg.sv
// rtl/or_bus_arbiter_pkg.sv - shared constants for the OR-bus arbiter
//
// Purpose : default word width and the logic-level constants used for
//           masking and reset values across the arbiter files.
// Ports   : none (package).
package or_bus_arbiter_pkg;

  localparam int   DEFAULT_WORD_WIDTH = 36;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/or_bus_arbiter_rr_priority_select.sv
// rtl/or_bus_arbiter_rr_priority_select.sv - combinational round-robin one-hot grant
//
// Purpose : picks the first set request bit searching upward from
//           last_grant+1 (modulo REQ_COUNT); purely combinational.
// Ports   :
//   req        in  [REQ_COUNT-1:0]  request vector
//   last_grant in  [IDX_W-1:0]      index of the most recent grant
//   grant      out [REQ_COUNT-1:0]  one-hot grant, zero when req is zero
module rr_priority_select
  import or_bus_arbiter_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  parameter int IDX_W     = $clog2(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [REQ_COUNT-1:0] grant
);

  logic [IDX_W-1:0]     start;
  logic [IDX_W:0]       back_shift;
  logic [REQ_COUNT-1:0] rotated;
  logic [REQ_COUNT-1:0] picked;

  always_comb begin
    // Search origin is one past the previous winner; the top index wraps to 0.
    // The explicit compare keeps this correct for non-power-of-two counts.
    if (last_grant >= IDX_W'(REQ_COUNT - 1)) begin
      start = '0;
    end else begin
      start = last_grant + IDX_W'(1);
    end

    // Rotating the doubled vector right by start puts the search origin at
    // bit 0, so a plain lowest-set-bit pick gives the round-robin winner.
    rotated = REQ_COUNT'({req, req} >> start);
    picked  = rotated & (~rotated + REQ_COUNT'(1));

    // Undo the rotation: shifting the doubled pick right by REQ_COUNT-start
    // is the same as rotating it left by start.
    back_shift = (IDX_W + 1)'(REQ_COUNT) - {LOW, start};
    grant      = REQ_COUNT'({picked, picked} >> back_shift);
  end

endmodule

// File: rtl/or_bus_arbiter.sv
// rtl/or_bus_arbiter.sv - round-robin arbiter sharing one registered OR-bus word
//
// Purpose : grants one requester per cycle, zeroes non-granted words and
//           OR-reduces them into a registered result with valid/ready.
// Ports   :
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   [REQ_COUNT-1:0]             per-requester valid
//   req_ready   out  [REQ_COUNT-1:0]             one-hot acceptance, 0 in reset
//   req_data    in   [WORD_WIDTH*REQ_COUNT-1:0]  word i at [W*(i+1)-1:W*i]
//   out_valid   out  result held in out_data/out_source
//   out_ready   in   downstream takes the result this cycle
//   out_data    out  [WORD_WIDTH-1:0]  registered OR of granted word
//   out_source  out  [REQ_COUNT-1:0]   registered one-hot source
//
// req_ready has a combinational path from out_ready, req_valid and reset_n;
// req_data never reaches any ready.
module or_bus_arbiter
  import or_bus_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int REQ_COUNT  = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [REQ_COUNT-1:0]            req_valid,
  output logic [REQ_COUNT-1:0]            req_ready,
  input  logic [WORD_WIDTH*REQ_COUNT-1:0] req_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WORD_WIDTH-1:0]           out_data,
  output logic [REQ_COUNT-1:0]            out_source
);

  localparam int IDX_W = $clog2(REQ_COUNT);

  logic [IDX_W-1:0]      last_grant;
  logic [REQ_COUNT-1:0]  grant;
  logic [WORD_WIDTH-1:0] masked_or;
  logic [IDX_W-1:0]      grant_idx;
  logic                  load;

  rr_priority_select #(
    .REQ_COUNT (REQ_COUNT),
    .IDX_W     (IDX_W)
  ) u_select (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // The output register can take a new word when empty or being drained.
  assign load = !out_valid || out_ready;

  // reset_n gates ready so nothing is acknowledged while held in reset
  // (out_valid is 0 then, which would otherwise open load).
  assign req_ready = (load && reset_n) ? grant : '0;

  // Non-granted words are forced to zero by selection rather than by AND,
  // so unknown bits on idle requesters cannot leak into the result.
  always_comb begin
    masked_or = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant[i] == HIGH) begin
        masked_or = masked_or | req_data[WORD_WIDTH*i +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant[i] == HIGH) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= LOW;
      out_data   <= '0;
      out_source <= '0;
      // Pointer at the top index gives requester 0 first priority.
      last_grant <= IDX_W'(REQ_COUNT - 1);
    end else if (load) begin
      out_valid  <= |grant;
      out_data   <= masked_or;
      out_source <= grant;
      if (|grant) begin
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_or_bus_arbiter.sv
// tb/tb_or_bus_arbiter.sv - scoreboard bench for or_bus_arbiter
module tb_or_bus_arbiter;

  localparam int W = 36;
  localparam int N = 4;

  logic             clock;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [W*N-1:0]   req_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [N-1:0]     out_source;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] src;
  } exp_t;

  exp_t exp_q[$];

  or_bus_arbiter #(.WORD_WIDTH(W), .REQ_COUNT(N)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_source (out_source)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic set_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input logic [W-1:0] w3);
    req_data = {w3, w2, w1, w0};
  endtask

  // Called at posedge+1; drives one cycle, checks ready at the negedge,
  // queues the hand-computed result, returns at the next posedge+1.
  task automatic step(input string name, input logic [N-1:0] v, input logic ordy,
                      input logic [N-1:0] exp_rdy, input logic [W-1:0] exp_word);
    exp_t e;
    req_valid = v;
    out_ready = ordy;
    @(negedge clock);
    check(name, W'(req_ready), W'(exp_rdy));
    if (exp_rdy != '0) begin
      e.data = exp_word;
      e.src  = exp_rdy;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: every completed output transfer is matched against the queue.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got data 0x%0h src %b with nothing expected", out_data, out_source);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_source !== e.src) begin
          fails++;
          $display("FAIL mon_result: got data 0x%0h src %b expected data 0x%0h src %b",
                   out_data, out_source, e.data, e.src);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    set_words(36'h1, 36'h2, 36'h4, 36'h8);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_out_source", W'(out_source), W'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Round robin with all requesters valid.
    step("rr0", 4'b1111, 1'b1, 4'b0001, 36'h1);
    step("rr1", 4'b1111, 1'b1, 4'b0010, 36'h2);
    step("rr2", 4'b1111, 1'b1, 4'b0100, 36'h4);
    step("rr3", 4'b1111, 1'b1, 4'b1000, 36'h8);
    step("rr4", 4'b1111, 1'b1, 4'b0001, 36'h1);

    // Backpressure after result 0x2.
    step("bp_first", 4'b1111, 1'b1, 4'b0010, 36'h2);
    for (int k = 0; k < 3; k++) begin
      step("bp_stall_ready", 4'b1111, 1'b0, 4'b0000, 36'h0);
      check("bp_stall_data", out_data, 36'h2);
      check("bp_stall_valid", W'(out_valid), W'(1));
    end
    step("bp_resume", 4'b1111, 1'b1, 4'b0100, 36'h4);
    step("bp_drain", 4'b0000, 1'b1, 4'b0000, 36'h0);

    // Sparse requests and pointer wrap.
    set_words(36'h11, 36'h22, 36'h33, 36'h44);
    step("sp_req3", 4'b1000, 1'b1, 4'b1000, 36'h44);
    step("sp_wrap2", 4'b0100, 1'b1, 4'b0100, 36'h33);
    step("sp_wrap0", 4'b0001, 1'b1, 4'b0001, 36'h11);
    step("single0", 4'b0001, 1'b1, 4'b0001, 36'h11);

    // Masking: non-granted words all ones.
    set_words(36'hF_FFFF_FFFF, 36'h0_0000_0005, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF);
    step("mask_one", 4'b0010, 1'b1, 4'b0010, 36'h5);
    set_words(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'h0_0000_0005, 36'hF_FFFF_FFFF);
    step("mask_all", 4'b1111, 1'b1, 4'b0100, 36'h5);

    // Requester 3 drops before acceptance; pointer must stay at 2.
    set_words(36'h11, 36'h22, 36'h33, 36'h44);
    step("drop_stall", 4'b1000, 1'b0, 4'b0000, 36'h0);
    step("drop_gone", 4'b0000, 1'b1, 4'b0000, 36'h0);
    step("drop_ptr", 4'b1001, 1'b1, 4'b1000, 36'h44);

    // Mid-operation reset while a result is held.
    step("mid_hold", 4'b0000, 1'b0, 4'b0000, 36'h0);
    check("mid_valid_before", W'(out_valid), W'(1));
    req_valid = 4'b1111;
    reset_n   = 1'b0;
    #1;
    check("mid_valid_async", W'(out_valid), W'(0));
    check("mid_data_async", out_data, W'(0));
    check("mid_ready_in_rst", W'(req_ready), W'(0));
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step("mid_restart", 4'b1111, 1'b1, 4'b0001, 36'h11);
    step("tail0", 4'b0000, 1'b1, 4'b0000, 36'h0);
    step("tail1", 4'b0000, 1'b1, 4'b0000, 36'h0);

    check("end_queue_empty", W'(exp_q.size()), W'(0));
    check("end_out_valid", W'(out_valid), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/or_bus_arbiter.md
Name: or_bus_arbiter

Overview:
Round-robin arbiter that shares one registered result word among REQ_COUNT requesters.
- Each requester offers a word with a valid/ready handshake.
- One requester is granted per cycle with a one-hot grant.
- Non-granted words are zeroed, so a word-wide OR-reduction acts as a mux.
- The reduced word is registered and presented downstream with valid/ready.
- Sits between the memory-mapped I/O units and the shared read-data/write-back bus.

Parameters:
WORD_WIDTH, 36, width of each requester word and of out_data
REQ_COUNT, 4, number of requesters (>=2)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  REQ_COUNT  bit i: requester i offers req_data word i
req_ready  output  REQ_COUNT  one-hot or zero; bit i: word i accepted this cycle
req_data  input  WORD_WIDTH*REQ_COUNT  word i at bits [WORD_WIDTH*(i+1)-1 : WORD_WIDTH*i]
out_valid  output  1  out_data/out_source hold a result
out_ready  input  1  downstream accepts result this cycle
out_data  output  WORD_WIDTH  registered OR-reduction of granted word
out_source  output  REQ_COUNT  registered one-hot index of the requester that produced out_data

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-low, reset_n.
- Reset values:
  - out_valid=0, out_data=0, out_source=0.
  - last_grant pointer = REQ_COUNT-1, so requester 0 has first priority.
- load = !out_valid | out_ready.
- grant (combinational, one-hot or zero): first set bit of req_valid, searching upward from last_grant+1 modulo REQ_COUNT.
- req_ready = load ? grant : 0.
  - Combinational path from out_ready and req_valid to req_ready is permitted and documented.
  - No path from req_data to any ready.
- Masked data: word i AND {WORD_WIDTH{grant[i]}}, OR-reduced across all i.
  - With no grant the result is all-zero.
- On a clock edge with load=1:
  - out_valid <= |grant; out_data <= masked OR; out_source <= grant.
  - If |grant, last_grant <= index of grant.
- On a clock edge with load=0: all registers hold; upstream sees req_ready=0.
- Latency: 1 cycle from the req_valid&req_ready edge to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Back-to-back: out_valid&out_ready plus a pending request in the same cycle reloads the register with no bubble.
- Fairness: with all requesters valid continuously, grants cycle 0,1,…,REQ_COUNT-1,0,…
  - Any requester with valid held waits at most REQ_COUNT-1 grants.
- Pointer wrap: last_grant=REQ_COUNT-1 searches from 0.
- Single requester: granted every cycle regardless of pointer.
- Requester drops req_valid before acceptance: no grant recorded; pointer unchanged.
- Reset asserted mid-transfer: out_valid drops immediately (asynchronously); a pending result is discarded; req_ready is 0 while reset_n=0.
- X-safety: req_data of non-granted requesters must not affect out_data.

Decomposition:
- Shared package constants: default WORD_WIDTH (36) and the logic-level constants HIGH/LOW used for masking and reset.
- Index width: clog2(REQ_COUNT), defined locally.
- One sub-module: rr_priority_select.
  - Inputs: request vector, last-grant index.
  - Output: one-hot grant, purely combinational.
  - Implemented by a double-width rotate-and-priority scheme.
- Masking, OR-reduction, output register and pointer register stay in or_bus_arbiter.

Test Plan:
- Reset: reset_n=0 with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_data=0; release reset -> first edge gives out_source=4'b0001.
- Round-robin: REQ_COUNT=4, all valid, words 0x1,0x2,0x4,0x8, out_ready=1 -> out_data sequence 0x1,0x2,0x4,0x8,0x1 on consecutive cycles.
- Backpressure: out_ready=0 after the first result 0x2 -> out_data stays 0x2 and req_ready=0 for all cycles stalled; out_ready=1 -> next grant resumes at requester 2.
- Sparse and wrap: last grant=3, req_valid=4'b0100 -> grant 4'b0100, out_data=word 2; then req_valid=4'b0001 -> grant 4'b0001.
- Masking: non-granted words all 0xFFFFFFFFF, granted word 0x000000005 -> out_data=0x000000005.
- Mid-operation reset: reset_n pulsed low while out_valid=1, out_ready=0 -> out_valid falls before the next edge; after release, arbitration restarts at requester 0.
